// File: rtl/router_src_ctrl_if.sv
// ----------------------------------------------------------------------------
// router_src_ctrl_if
// Source-side bus of the 1x3 router ingress.
//   pkt_valid : source -> router, high on header/payload, low on parity byte
//   data_in   : source -> router, packet byte
//   busy      : router -> source, hold data_in/pkt_valid while high
//   err       : router -> source, result of the last checked packet
// master = packet source, slave = router_src_ctrl.
// ----------------------------------------------------------------------------
interface router_src_ctrl_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       busy;
  logic       err;

  modport master (output pkt_valid, output data_in, input busy, input err);
  modport slave  (input pkt_valid, input data_in, output busy, output err);
endinterface

// File: rtl/router_src_ctrl.sv
// ----------------------------------------------------------------------------
// router_src_ctrl
// Ingress controller of the 1x3 router. Decodes the destination from each
// packet header and steers header, payload and parity bytes into one of three
// output FIFOs. The source is back-pressured while the target FIFO is full or
// a packet check is in progress. Length and parity are checked per packet,
// and packet/error statistics are kept in saturating counters.
// Ports:
//   clk        : system clock, all state on posedge
//   resetn     : asynchronous active-low reset
//   src        : source bus (pkt_valid, data_in, busy, err), slave side
//   fifo_full  : full flag per output FIFO
//   fifo_wr_en : one-hot FIFO write strobe (combinational)
//   fifo_din   : byte to FIFO (combinational, 0 when not writing)
//   pkt_done   : one-cycle pulse when a packet check completes
//   pkt_cnt    : packets completed, saturating
//   err_cnt    : packets flagged with err, saturating
// ----------------------------------------------------------------------------
module router_src_ctrl #(
  parameter int CNT_W    = 16,
  parameter int NUM_DEST = 3
) (
  input  logic                clk,
  input  logic                resetn,
  router_src_ctrl_if.slave    src,
  input  logic [NUM_DEST-1:0] fifo_full,
  output logic [NUM_DEST-1:0] fifo_wr_en,
  output logic [7:0]          fifo_din,
  output logic                pkt_done,
  output logic [CNT_W-1:0]    pkt_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam logic [1:0] DEST_INVALID = 2'd3;

  state_t     state;
  logic [1:0] dest_reg;
  logic [5:0] len_reg;
  logic       drop_reg;
  logic [7:0] parity_acc;
  logic [6:0] pay_cnt;
  logic       parity_ok;
  logic       len_ok;
  logic       err_q;

  logic [1:0] hdr_dest;
  logic       hdr_full;
  logic       pay_full;
  logic       busy_c;
  logic       accept;
  logic [1:0] wr_dest;
  logic       wr_ok;
  logic       chk_err;

  assign hdr_dest = src.data_in[1:0];
  assign chk_err  = !parity_ok || !len_ok || drop_reg;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    hdr_full   = 1'b0;
    pay_full   = 1'b0;
    busy_c     = 1'b0;
    wr_dest    = dest_reg;
    wr_ok      = !drop_reg;
    fifo_wr_en = '0;

    // Full flag of the header's / latched destination; address 3 never matches.
    for (int i = 0; i < NUM_DEST; i++) begin
      hdr_full = hdr_full | (fifo_full[i] && (hdr_dest == 2'(i)));
      pay_full = pay_full | (fifo_full[i] && (dest_reg == 2'(i)));
    end

    unique case (state)
      IDLE:    busy_c = src.pkt_valid && hdr_full;
      PAYLOAD: busy_c = pay_full && !drop_reg;
      CHECK:   busy_c = 1'b1;
      default: busy_c = 1'b0;
    endcase

    // While reset is asserted nothing is accepted and the source is not stalled.
    busy_c = busy_c && resetn;
    accept = resetn && !busy_c &&
             (((state == IDLE) && src.pkt_valid) || (state == PAYLOAD));

    // In IDLE the byte is the header itself, so the destination comes from data_in.
    if (state == IDLE) begin
      wr_dest = hdr_dest;
      wr_ok   = (hdr_dest != DEST_INVALID);
    end

    for (int i = 0; i < NUM_DEST; i++)
      fifo_wr_en[i] = accept && wr_ok && (wr_dest == 2'(i));

    fifo_din = (|fifo_wr_en) ? src.data_in : 8'h00;
  end

  assign src.busy = busy_c;
  assign src.err  = err_q;

  // NOTE: sequential state uses non-blocking assignments only, so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      dest_reg   <= 2'd0;
      len_reg    <= 6'd0;
      drop_reg   <= 1'b0;
      parity_acc <= 8'h00;
      pay_cnt    <= 7'd0;
      parity_ok  <= 1'b0;
      len_ok     <= 1'b0;
      err_q      <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      pkt_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            dest_reg   <= hdr_dest;
            len_reg    <= src.data_in[7:2];
            drop_reg   <= (hdr_dest == DEST_INVALID);
            parity_acc <= src.data_in;
            pay_cnt    <= 7'd0;
            err_q      <= 1'b0;
            state      <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            if (src.pkt_valid) begin
              parity_acc <= parity_acc ^ src.data_in;
              if (pay_cnt != 7'h7f) pay_cnt <= pay_cnt + 7'd1;
            end else begin
              // pkt_valid low marks the parity byte: capture both checks now.
              parity_ok <= (parity_acc == src.data_in);
              len_ok    <= (pay_cnt == {1'b0, len_reg});
              state     <= CHECK;
            end
          end
        end
        CHECK: begin
          err_q    <= chk_err;
          pkt_done <= 1'b1;
          if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
          if (chk_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
